// File: rtl/jt_dump_ctrl.sv
// jt_dump_ctrl
//   Scheduler for the simulation waveform-dump window. Counts frames on the
//   falling edge of vs, optionally waits for a ROM download (led) to end, and
//   opens the dump window at frame START_FRAME. dump_start / dump_stop are
//   single-cycle pulses meant to drive the simulator's dump on/off hooks.
//
//   Build option: define DUMP_STOP_EN to close the window automatically after
//   LEN_FRAMES frames (state DONE). Without it the window is closed only by a
//   new download (led rising) or by rst.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active high
//   vs         in   1   vertical sync, active high, synchronous to clk
//   led        in   1   download in progress, active high, synchronous to clk
//   frame_cnt  out  32  number of vs falling edges since reset (wraps)
//   dump_on    out  1   dump window open
//   dump_start out  1   one-cycle pulse when the window opens
//   dump_stop  out  1   one-cycle pulse when the window closes
//   st         out  3   FSM state code (debug)
//
// State  | code | meaning
// IDLE   | 0    | in reset / first cycle after reset
// WAIT_DL| 1    | waiting for a download to finish (led falling, settled)
// WAIT_FR| 2    | armed, waiting for a vs fall at or past START_FRAME
// DUMPING| 3    | dump window open
// DONE   | 4    | window closed for good, until rst
module jt_dump_ctrl #(
  parameter int START_FRAME = 0,
  parameter int LEN_FRAMES  = 4,
  parameter int WAIT_DL     = 1,
  parameter int SETTLE      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        led,
  output logic [31:0] frame_cnt,
  output logic        dump_on,
  output logic        dump_start,
  output logic        dump_stop,
  output logic [2:0]  st
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_DL    = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_DUMPING    = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  state_t        r_st;
  logic          r_vs_l;
  logic          r_led_l;
  logic [31:0]   r_frame_cnt;
  logic [SW-1:0] r_settle;
  logic          r_dump_on;
  logic          r_dump_start;
  logic          r_dump_stop;

  logic w_vs_fall;
  logic w_led_fall;
  logic w_led_rise;
  logic w_settled;
  logic w_start_ok;

  assign w_vs_fall  = r_vs_l & ~vs;
  assign w_led_fall = r_led_l & ~led;
  assign w_led_rise = ~r_led_l & led;
  assign w_settled  = (r_settle == SW'(SETTLE));
  // Compare against the count before this vs fall is added.
  assign w_start_ok = (r_frame_cnt >= 32'(START_FRAME));

`ifdef DUMP_STOP_EN
  localparam int LEN_EFF = (LEN_FRAMES < 1) ? 1 : LEN_FRAMES;
  logic [31:0] r_len;
`else
  logic w_unused_len;
  assign w_unused_len = (LEN_FRAMES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st         <= S_IDLE;
      r_vs_l       <= 1'b0;
      r_led_l      <= 1'b0;
      r_frame_cnt  <= '0;
      r_settle     <= '0;
      r_dump_on    <= 1'b0;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
`ifdef DUMP_STOP_EN
      r_len        <= '0;
`endif
    end else begin
      r_vs_l       <= vs;
      r_led_l      <= led;
      r_dump_start <= 1'b0;
      r_dump_stop  <= 1'b0;
      if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (!w_settled) r_settle <= r_settle + 1'b1;

      case (r_st)
        S_IDLE: r_st <= (WAIT_DL != 0) ? S_WAIT_DL : S_WAIT_FRAME;

        // A vs fall in the same cycle as the led fall is consumed here and
        // cannot open the window.
        S_WAIT_DL: if (w_led_fall && w_settled) r_st <= S_WAIT_FRAME;

        S_WAIT_FRAME: begin
          if (w_led_rise && (WAIT_DL != 0)) begin
            r_st <= S_WAIT_DL;
          end else if (w_vs_fall && w_start_ok) begin
            r_st         <= S_DUMPING;
            r_dump_on    <= 1'b1;
            r_dump_start <= 1'b1;
`ifdef DUMP_STOP_EN
            r_len        <= '0;
`endif
          end
        end

        // led_rise has priority over the length stop so only one
        // dump_stop is produced.
        S_DUMPING: begin
          if (w_led_rise && (WAIT_DL != 0)) begin
            r_st        <= S_WAIT_DL;
            r_dump_on   <= 1'b0;
            r_dump_stop <= 1'b1;
          end
`ifdef DUMP_STOP_EN
          else if (w_vs_fall) begin
            if (r_len == 32'(LEN_EFF - 1)) begin
              r_st        <= S_DONE;
              r_dump_on   <= 1'b0;
              r_dump_stop <= 1'b1;
            end else begin
              r_len <= r_len + 32'd1;
            end
          end
`endif
        end

        S_DONE: r_st <= S_DONE;

        default: begin
          r_st      <= S_IDLE;
          r_dump_on <= 1'b0;
        end
      endcase
    end
  end

  assign frame_cnt  = r_frame_cnt;
  assign dump_on    = r_dump_on;
  assign dump_start = r_dump_start;
  assign dump_stop  = r_dump_stop;
  assign st         = r_st;

endmodule

// File: tb/tb_jt_dump_ctrl.sv
module tb_jt_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs_a = 1'b0, led_a = 1'b0;
  logic        vs_b = 1'b0, led_b = 1'b0;
  logic [31:0] fc_a, fc_b;
  logic        on_a, start_a, stop_a;
  logic        on_b, start_b, stop_b;
  logic [2:0]  st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // A: no download wait, opens at frame 3
  jt_dump_ctrl #(.START_FRAME(3), .LEN_FRAMES(4), .WAIT_DL(0), .SETTLE(16)) dut_a (
    .clk(clk), .rst(rst), .vs(vs_a), .led(led_a), .frame_cnt(fc_a),
    .dump_on(on_a), .dump_start(start_a), .dump_stop(stop_a), .st(st_a));

  // B: waits for download, opens at frame 0, length 2
  jt_dump_ctrl #(.START_FRAME(0), .LEN_FRAMES(2), .WAIT_DL(1), .SETTLE(16)) dut_b (
    .clk(clk), .rst(rst), .vs(vs_b), .led(led_b), .frame_cnt(fc_b),
    .dump_on(on_b), .dump_start(start_b), .dump_stop(stop_b), .st(st_b));

  task automatic do_reset();
    vs_a = 0; led_a = 0; vs_b = 0; led_b = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic pulse_a();
    vs_a = 1; @(negedge clk);
    vs_a = 0; @(negedge clk);
  endtask

  task automatic pulse_b();
    vs_b = 1; @(negedge clk);
    vs_b = 0; @(negedge clk);
  endtask

  task automatic test_reset();
    vs_a = 0; led_a = 0; vs_b = 0; led_b = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (fc_a !== 32'd0) begin n_errors++; $display("FAIL rst_fc_a got %0h exp 0", fc_a); end
    n_checks++; if ({on_a, start_a, stop_a} !== 3'b000) begin n_errors++; $display("FAIL rst_out_a got %b exp 000", {on_a, start_a, stop_a}); end
    n_checks++; if ({on_b, start_b, stop_b} !== 3'b000) begin n_errors++; $display("FAIL rst_out_b got %b exp 000", {on_b, start_b, stop_b}); end
    n_checks++; if (st_a !== 3'd0 || st_b !== 3'd0) begin n_errors++; $display("FAIL rst_st got %0d/%0d exp 0/0", st_a, st_b); end
    rst = 0;
    @(negedge clk);
    n_checks++; if (st_a !== 3'd2) begin n_errors++; $display("FAIL idle_exit_a got %0d exp 2", st_a); end
    n_checks++; if (st_b !== 3'd1) begin n_errors++; $display("FAIL idle_exit_b got %0d exp 1", st_b); end
  endtask

  task automatic test_start_frame();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      pulse_a();
      n_checks++; if (start_a !== 1'b0 || on_a !== 1'b0) begin n_errors++; $display("FAIL early_start_%0d got start=%b on=%b exp 0/0", i, start_a, on_a); end
      n_checks++; if (fc_a !== 32'(i)) begin n_errors++; $display("FAIL fc_%0d got %0d exp %0d", i, fc_a, i); end
    end
    pulse_a();
    n_checks++; if (start_a !== 1'b1 || on_a !== 1'b1) begin n_errors++; $display("FAIL start4 got start=%b on=%b exp 1/1", start_a, on_a); end
    n_checks++; if (fc_a !== 32'd4) begin n_errors++; $display("FAIL start4_fc got %0d exp 4", fc_a); end
    n_checks++; if (st_a !== 3'd3) begin n_errors++; $display("FAIL start4_st got %0d exp 3", st_a); end
    vs_a = 1; @(negedge clk);
    n_checks++; if (start_a !== 1'b0) begin n_errors++; $display("FAIL start_width got %b exp 0", start_a); end
    vs_a = 0; @(negedge clk);
    pulse_a();
    n_checks++; if (on_a !== 1'b1 || start_a !== 1'b0 || fc_a !== 32'd6) begin n_errors++; $display("FAIL hold_a got on=%b start=%b fc=%0d exp 1/0/6", on_a, start_a, fc_a); end
  endtask

  task automatic test_settle();
    do_reset();
    led_b = 1;
    repeat (3) @(negedge clk);
    led_b = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (st_b !== 3'd1) begin n_errors++; $display("FAIL early_led got st=%0d exp 1", st_b); end
    repeat (90) @(negedge clk);
    led_b = 1; @(negedge clk);
    led_b = 0; @(negedge clk);
    n_checks++; if (st_b !== 3'd2 || start_b !== 1'b0) begin n_errors++; $display("FAIL armed got st=%0d start=%b exp 2/0", st_b, start_b); end
    pulse_b();
    n_checks++; if (start_b !== 1'b1 || on_b !== 1'b1 || st_b !== 3'd3) begin n_errors++; $display("FAIL dl_start got start=%b on=%b st=%0d exp 1/1/3", start_b, on_b, st_b); end
    n_checks++; if (fc_b !== 32'd1) begin n_errors++; $display("FAIL dl_start_fc got %0d exp 1", fc_b); end
  endtask

  task automatic test_led_restart();
    led_b = 1; @(negedge clk);
    n_checks++; if (stop_b !== 1'b1 || on_b !== 1'b0 || st_b !== 3'd1) begin n_errors++; $display("FAIL restart_stop got stop=%b on=%b st=%0d exp 1/0/1", stop_b, on_b, st_b); end
    led_b = 0; @(negedge clk);
    n_checks++; if (stop_b !== 1'b0 || st_b !== 3'd2) begin n_errors++; $display("FAIL restart_arm got stop=%b st=%0d exp 0/2", stop_b, st_b); end
    pulse_b();
    n_checks++; if (start_b !== 1'b1 || on_b !== 1'b1 || stop_b !== 1'b0) begin n_errors++; $display("FAIL restart_start got start=%b on=%b stop=%b exp 1/1/0", start_b, on_b, stop_b); end
  endtask

`ifdef DUMP_STOP_EN
  task automatic test_length();
    int n_p;
    pulse_b();
    n_checks++; if (stop_b !== 1'b0 || on_b !== 1'b1) begin n_errors++; $display("FAIL len1 got stop=%b on=%b exp 0/1", stop_b, on_b); end
    pulse_b();
    n_checks++; if (stop_b !== 1'b1 || on_b !== 1'b0 || st_b !== 3'd4 || start_b !== 1'b0) begin n_errors++; $display("FAIL len2 got stop=%b on=%b st=%0d start=%b exp 1/0/4/0", stop_b, on_b, st_b, start_b); end
    n_p = 0;
    for (int i = 0; i < 24; i++) begin
      vs_b = i[1]; led_b = i[2];
      @(negedge clk);
      if (start_b || stop_b) n_p++;
    end
    vs_b = 0; led_b = 0;
    n_checks++; if (n_p !== 0 || st_b !== 3'd4 || on_b !== 1'b0) begin n_errors++; $display("FAIL done_sticky got pulses=%0d st=%0d on=%b exp 0/4/0", n_p, st_b, on_b); end
  endtask
`else
  task automatic test_length();
    int n_p;
    n_p = 0;
    for (int i = 0; i < 12; i++) begin
      vs_b = i[0];
      @(negedge clk);
      if (start_b || stop_b) n_p++;
    end
    vs_b = 0;
    n_checks++; if (n_p !== 0 || on_b !== 1'b1 || st_b !== 3'd3) begin n_errors++; $display("FAIL no_len_stop got pulses=%0d on=%b st=%0d exp 0/1/3", n_p, on_b, st_b); end
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    repeat (20) @(negedge clk);
    dut_b.r_frame_cnt = 32'hFFFF_FFFF;
    pulse_b();
    n_checks++; if (fc_b !== 32'd0) begin n_errors++; $display("FAIL wrap_fc got %0h exp 0", fc_b); end
    n_checks++; if (start_b !== 1'b0 || stop_b !== 1'b0 || st_b !== 3'd1) begin n_errors++; $display("FAIL wrap_quiet got start=%b stop=%b st=%0d exp 0/0/1", start_b, stop_b, st_b); end
    vs_b = 1; led_b = 1; @(negedge clk);
    vs_b = 0; led_b = 0; @(negedge clk);
    n_checks++; if (st_b !== 3'd2 || start_b !== 1'b0 || fc_b !== 32'd1) begin n_errors++; $display("FAIL same_cycle got st=%0d start=%b fc=%0d exp 2/0/1", st_b, start_b, fc_b); end
    @(negedge clk);
    n_checks++; if (start_b !== 1'b0) begin n_errors++; $display("FAIL same_cycle_late got start=%b exp 0", start_b); end
    pulse_b();
    n_checks++; if (start_b !== 1'b1 || fc_b !== 32'd2) begin n_errors++; $display("FAIL post_wrap_start got start=%b fc=%0d exp 1/2", start_b, fc_b); end
  endtask

  task automatic test_rst_mid();
    rst = 1; @(negedge clk);
    n_checks++; if (on_b !== 1'b0 || stop_b !== 1'b0) begin n_errors++; $display("FAIL rst_mid_out got on=%b stop=%b exp 0/0", on_b, stop_b); end
    n_checks++; if (fc_b !== 32'd0 || st_b !== 3'd0) begin n_errors++; $display("FAIL rst_mid_state got fc=%0d st=%0d exp 0/0", fc_b, st_b); end
    rst = 0; @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_frame();
    test_settle();
    test_led_restart();
    test_length();
    test_wrap();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
